// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types and constants for the DVI transmitter init sequencer
package dvi_pkg;

    // CH7301 7-bit slave address (0xEC as the write byte)
    localparam logic [6:0] CH7301_DEV_ADDR = 7'h76;

    // Default timing at 125 MHz: 1 ms power-up wait, 100 us retry gap
    localparam int PWR_DELAY_125M = 125000;
    localparam int RETRY_GAP_125M = 12500;

    // Delay/gap counter width, large enough for the longer of the two waits
    localparam int CNT_W = 17;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_FINISH,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/dvi_init_sequencer_if.sv
// rtl/dvi_init_sequencer_if.sv - register-write request channel to the shared I2C write engine
interface dvi_init_sequencer_if;

    logic       req;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic       ack;
    logic       nack;

    modport master (
        output req,
        output dev,
        output reg_addr,
        output data,
        input  ack,
        input  nack
    );

    modport slave (
        input  req,
        input  dev,
        input  reg_addr,
        input  data,
        output ack,
        output nack
    );

endinterface

// File: rtl/dvi_init_delay_cnt.sv
// rtl/dvi_init_delay_cnt.sv - loadable down-counter with zero flag, shared by power-up wait and retry gap
module dvi_init_delay_cnt
    import dvi_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero so the flag stays put
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dvi_init_sequencer.sv
// rtl/dvi_init_sequencer.sv - walks the DVI transmitter register-init table and issues I2C writes
module dvi_init_sequencer
    import dvi_pkg::*;
#(
    parameter logic [6:0] I2C_DEV_ADDR = CH7301_DEV_ADDR,
    parameter int         N_ENTRIES    = 16,
    parameter int         TBL_AW       = 5,
    parameter int         PWR_DELAY    = PWR_DELAY_125M,
    parameter int         MAX_RETRY    = 3,
    parameter int         RETRY_GAP    = RETRY_GAP_125M
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [TBL_AW-1:0]    tbl_addr,
    input  logic [15:0]          tbl_data,
    dvi_init_sequencer_if.master xfer,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [TBL_AW-1:0]    err_index
);

    localparam logic [TBL_AW-1:0] LAST_ADDR = TBL_AW'(N_ENTRIES - 1);

    state_t     state;
    logic [1:0] retry;
    logic       req_q;
    logic [7:0] reg_q;
    logic [7:0] data_q;

    logic             ack_take;
    logic             retry_ok;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // REQ rises on entry to ISSUE, so an ACK in ISSUE is the one coincident
    // with the rising edge and is accepted; an ACK anywhere else is stray
    assign ack_take = xfer.ack && req_q && ((state == ST_ISSUE) || (state == ST_WAIT_ACK));
    assign retry_ok = (int'(retry) < MAX_RETRY);
    assign cnt_dec  = (state == ST_PWR_WAIT) || (state == ST_GAP);

    // Pick which wait the shared counter is loaded for
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = CNT_W'(RETRY_GAP - 1);
        if ((state == ST_IDLE) && start) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(PWR_DELAY - 1);
        end else if (ack_take && xfer.nack && retry_ok) begin
            cnt_load = 1'b1;
        end
    end

    dvi_init_delay_cnt #(.W(CNT_W)) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer FSM with registered table address, request payload and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            retry     <= 2'd0;
            tbl_addr  <= '0;
            req_q     <= 1'b0;
            reg_q     <= 8'h00;
            data_q    <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_PWR_WAIT;
                    end
                end
                ST_PWR_WAIT: begin
                    if (cnt_zero) begin
                        tbl_addr <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    reg_q  <= tbl_data[15:8];
                    data_q <= tbl_data[7:0];
                    retry  <= 2'd0;
                    req_q  <= 1'b1;
                    state  <= ST_ISSUE;
                end
                ST_ISSUE, ST_WAIT_ACK: begin
                    if (ack_take) begin
                        req_q <= 1'b0;
                        if (!xfer.nack) begin
                            if (tbl_addr == LAST_ADDR) begin
                                state <= ST_FINISH;
                            end else begin
                                tbl_addr <= tbl_addr + 1'b1;
                                state    <= ST_FETCH;
                            end
                        end else if (retry_ok) begin
                            retry <= retry + 2'd1;
                            state <= ST_GAP;
                        end else begin
                            err_index <= tbl_addr;
                            state     <= ST_FAIL;
                        end
                    end else begin
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        req_q <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_FAIL: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign xfer.req      = req_q;
    assign xfer.dev      = I2C_DEV_ADDR;
    assign xfer.reg_addr = reg_q;
    assign xfer.data     = data_q;

endmodule

// File: doc/dvi_init_sequencer.md
Name: dvi_init_sequencer

Overview:
Hardware sequencer that configures the Chrontel DVI transmitter over I2C at power-up. No soft processor is involved.
- Walks a register-init table of {reg, value} pairs held in an external block-RAM ROM.
- Issues one I2C register write per entry to the shared I2C write engine.
- Retries entries that NACK and reports done/error status to the video top level.

Parameters:
I2C_DEV_ADDR, 7'h76, 7-bit I2C slave address of the DVI transmitter (0xEC write byte).
N_ENTRIES, 16, number of valid table entries (1..2**TBL_AW).
TBL_AW, 5, table address width.
PWR_DELAY, 125000, CLK cycles to wait after START before the first write (1 ms at 125 MHz); minimum 1.
MAX_RETRY, 3, extra attempts per entry after a NACK.
RETRY_GAP, 12500, idle CLK cycles between a NACK and its retry (100 us); minimum 1.

Ports:
CLK  in  1  system clock, 125 MHz
RST  in  1  reset, synchronous, active-high
START  in  1  single-cycle pulse; begins a sequence; ignored while BUSY
TBL_ADDR  out  TBL_AW  table read address
TBL_DATA  in  16  table word, [15:8]=reg, [7:0]=value; valid 1 cycle after TBL_ADDR changes
XFER_REQ  out  1  write request to the I2C engine
XFER_DEV  out  7  device address (constant I2C_DEV_ADDR)
XFER_REG  out  8  register address
XFER_DATA  out  8  register value
XFER_ACK  in  1  single-cycle completion pulse from the engine
XFER_NACK  in  1  qualifies XFER_ACK: 1 = slave did not acknowledge
BUSY  out  1  sequence in progress
DONE  out  1  sticky; all entries written
ERROR  out  1  sticky; an entry exhausted its retries
ERR_INDEX  out  TBL_AW  index of the failing entry

Behaviour:
- Reset values: all outputs 0 (TBL_ADDR=0, XFER_REQ=0, XFER_REG/XFER_DATA=0, BUSY=0, DONE=0, ERROR=0, ERR_INDEX=0); state IDLE, all counters 0. XFER_DEV is always I2C_DEV_ADDR.
- State machine: IDLE, PWR_WAIT, FETCH, LATCH, ISSUE, WAIT_ACK, GAP, FINISH, FAIL.
- IDLE:
  - On START, clear DONE and ERROR, set BUSY, load delay counter with PWR_DELAY-1, go to PWR_WAIT.
  - A START arriving while BUSY=1 is ignored.
- PWR_WAIT: decrement the counter each cycle; at 0, set TBL_ADDR=0 and go to FETCH.
- FETCH: one-cycle wait for the ROM read latency; go to LATCH.
- LATCH: register TBL_DATA into XFER_REG/XFER_DATA, clear the retry counter, go to ISSUE.
- ISSUE: assert XFER_REQ, go to WAIT_ACK.
- XFER handshake:
  - XFER_REQ stays high with a stable payload until XFER_ACK is sampled high.
  - XFER_REQ drops on the cycle after ACK.
  - An ACK received while REQ=0 is ignored.
  - An ACK coincident with the REQ rising edge is accepted.
- WAIT_ACK on ACK with NACK=0:
  - If TBL_ADDR == N_ENTRIES-1, go to FINISH.
  - Otherwise increment TBL_ADDR and go to FETCH.
- WAIT_ACK on ACK with NACK=1:
  - If retry counter < MAX_RETRY, increment it, load the gap counter with RETRY_GAP-1, go to GAP.
  - Otherwise set ERR_INDEX=TBL_ADDR and go to FAIL.
- GAP: count down; at 0, go to ISSUE with the same payload (no re-fetch).
- FINISH: DONE=1, BUSY=0, go to IDLE. FAIL: ERROR=1, BUSY=0, go to IDLE. DONE and ERROR are never both 1.
- Minimum time per successful entry: FETCH, LATCH, ISSUE, then WAIT_ACK, plus engine latency.
- No timeout in this block: the I2C engine guarantees an ACK for every REQ.
- Counters: delay/gap counter is 17 bits, sized by the larger of PWR_DELAY and RETRY_GAP. Retry counter is 2 bits. TBL_ADDR never wraps past N_ENTRIES-1.
- RST mid-operation: immediate return to reset values, including dropping XFER_REQ. The I2C engine is reset by the same RST.

Decomposition:
- Shared package dvi_pkg:
  - state encoding enum.
  - CH7301 device address constant 7'h76.
  - default timing constants for 125 MHz (PWR_DELAY, RETRY_GAP).
- One sub-module: dvi_init_delay_cnt, a loadable down-counter with a zero flag. It is shared by PWR_WAIT and GAP.
- The table ROM itself is instantiated outside this block.

Test Plan:
1. Reset, then START with N_ENTRIES=4, PWR_DELAY=10, table {21:09, 1D:43, 23:08, 49:C0}, engine ACKs 5 cycles after REQ with NACK=0 -> four REQs with payloads 0x76/21/09 ... 0x76/49/C0 in order; first REQ exactly 12 cycles after START; DONE=1, BUSY=0, ERROR=0.
2. Engine NACKs entry 1 twice, then ACKs -> entry 1 is issued 3 times, each retry REQ ≥ RETRY_GAP cycles after the NACK; entry 2 follows; DONE=1.
3. Engine always NACKs entry 2 with MAX_RETRY=3 -> entry 2 is issued 4 times, then ERROR=1, ERR_INDEX=2, DONE=0, no REQ for entry 3.
4. START pulsed again while BUSY -> ignored, sequence unchanged. START after DONE -> DONE clears and the full sequence repeats.
5. RST asserted while XFER_REQ=1 in WAIT_ACK -> next cycle all outputs 0, state IDLE; a later START restarts from entry 0.
6. Spurious XFER_ACK while REQ=0 (during PWR_WAIT), and ACK on the same cycle REQ rises -> spurious ACK ignored, coincident ACK accepted, entry order intact.
